// File: rtl/loader_pkg.sv
// Shared definitions for the serial ROM loader.
//   loader_state_t : frame-parser FSM state encoding (7 states, 3 bits)
//   SYNC_BYTE_DEF  : default frame start marker
//   TIMEOUT_DEF    : default inter-byte timeout in clk cycles (20 ms at 100 MHz)
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_H = 3'd1,
        ST_ADDR_L = 3'd2,
        ST_LEN_H  = 3'd3,
        ST_LEN_L  = 3'd4,
        ST_DATA   = 3'd5,
        ST_CSUM   = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         TIMEOUT_DEF   = 2000000;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer with falling-edge detect for an asynchronous strobe.
// The first two flops resynchronize, the third holds the previous synchronized
// level so a falling edge can be detected.
//   clk        : sampling clock
//   reset_n    : asynchronous active-low reset, clears all flops
//   async_in   : strobe from another clock domain
//   fall_pulse : one-cycle pulse on a falling edge of the synchronized strobe
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic fall_pulse
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[1] is the synchronized level, sync_q[2] the level one cycle earlier.
    assign fall_pulse = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/serial_loader.sv
// Framed, checksummed BIOS ROM loader fed by a UART receiver.
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CSUM.
// The checksum covers the data bytes only; (sum(data) + csum) mod 256 == 0.
// The CPU is held in reset from the SYNC byte until a frame ends cleanly.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for SYNC_BYTE, other bytes ignored
//   ADDR_H  | expecting start address, high byte
//   ADDR_L  | expecting start address, low byte
//   LEN_H   | expecting byte count, high byte
//   LEN_L   | expecting byte count, low byte (0 -> CSUM)
//   DATA    | each byte written to ROM, address advances
//   CSUM    | checksum byte, frame resolves good or bad
//
// Ports:
//   clk, reset_n        : 100 MHz clock, async active-low reset
//   rx_byte, rx_ready   : UART byte and its (asynchronous) strobe
//   prg_addr/data/wren  : ROM write port, wren is a one-cycle strobe
//   cpu_hold            : holds the CPU in reset
//   load_done           : one-cycle pulse on a good frame
//   load_err            : sticky error (bad checksum or timeout)
//   busy                : FSM outside IDLE
module serial_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic [ADDR_W-1:0] prg_addr,
    output logic [7:0]        prg_data,
    output logic              prg_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic bev;

    loader_state_t     state_q,     state_d;
    logic [7:0]        addr_hi_q,   addr_hi_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [15:0]       len_q,       len_d;
    logic [7:0]        acc_q,       acc_d;
    logic [TMR_W-1:0]  tmr_q,       tmr_d;
    logic [ADDR_W-1:0] prg_addr_q,  prg_addr_d;
    logic [7:0]        prg_data_q,  prg_data_d;
    logic              prg_wren_q,  prg_wren_d;
    logic              cpu_hold_q,  cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q,  load_err_d;

    logic [15:0] addr_full;
    logic [15:0] len_full;
    logic [7:0]  acc_sum;
    logic        timeout;

    sync_edge u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .async_in   (rx_ready),
        .fall_pulse (bev)
    );

    assign addr_full = {addr_hi_q, rx_byte};
    assign len_full  = {len_q[15:8], rx_byte};
    assign acc_sum   = acc_q + rx_byte;
    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign timeout   = (state_q != ST_IDLE) && (tmr_q == '0) && !bev;

    // Inter-byte timer: reloaded on every byte and while idle, counts down otherwise.
    always_comb begin
        tmr_d = tmr_q;
        if (bev || state_q == ST_IDLE) begin
            tmr_d = TMR_W'(TIMEOUT);
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        len_d       = len_q;
        acc_d       = acc_q;
        prg_addr_d  = prg_addr_q;
        prg_data_d  = prg_data_q;
        prg_wren_d  = 1'b0;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;

        if (bev) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        cpu_hold_d = 1'b1;
                        load_err_d = 1'b0;
                        acc_d      = 8'h00;
                        state_d    = ST_ADDR_H;
                    end
                end
                ST_ADDR_H: begin
                    addr_hi_d = rx_byte;
                    state_d   = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    addr_d  = addr_full[ADDR_W-1:0];
                    state_d = ST_LEN_H;
                end
                ST_LEN_H: begin
                    len_d   = {rx_byte, 8'h00};
                    state_d = ST_LEN_L;
                end
                ST_LEN_L: begin
                    len_d   = len_full;
                    state_d = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    prg_addr_d = addr_q;
                    prg_data_d = rx_byte;
                    prg_wren_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    acc_d      = acc_sum;
                    len_d      = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (acc_sum == 8'h00) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            load_err_d = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_hi_q   <= 8'h00;
            addr_q      <= '0;
            len_q       <= 16'd0;
            acc_q       <= 8'h00;
            tmr_q       <= '0;
            prg_addr_q  <= '0;
            prg_data_q  <= 8'h00;
            prg_wren_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            tmr_q       <= tmr_d;
            prg_addr_q  <= prg_addr_d;
            prg_data_q  <= prg_data_d;
            prg_wren_q  <= prg_wren_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign prg_addr  = prg_addr_q;
    assign prg_data  = prg_data_q;
    assign prg_wren  = prg_wren_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: framed loads, checksum errors, address wrap,
// leading garbage, inter-byte timeout and reset in the middle of a frame.
module tb_serial_loader;

    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 200;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              rx_ready = 1'b0;
    logic [ADDR_W-1:0] prg_addr;
    logic [7:0]        prg_data;
    logic              prg_wren;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [7:0]        wr_data[$];
    int                done_cnt = 0;
    int                wren_long = 0;
    logic              wren_prev = 1'b0;

    int wb;
    int db;

    always #5 clk = ~clk;

    serial_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .prg_addr  (prg_addr),
        .prg_data  (prg_data),
        .prg_wren  (prg_wren),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .busy      (busy)
    );

    // Write/pulse log, sampled away from the active edge.
    always @(negedge clk) begin
        if (prg_wren) begin
            wr_addr.push_back(prg_addr);
            wr_data.push_back(prg_data);
        end
        if (prg_wren && wren_prev) wren_long++;
        wren_prev = prg_wren;
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic mark();
        wb = wr_addr.size();
        db = done_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(prg_addr), 32'h0);
        check("rst_data", 32'(prg_data), 32'h0);
        check("rst_wren", 32'(prg_wren), 32'h0);
        check("rst_hold", 32'(cpu_hold), 32'h0);
        check("rst_done", 32'(load_done), 32'h0);
        check("rst_err", 32'(load_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame at 0x0010
        mark();
        send_byte(8'hA5);
        check("a_busy", 32'(busy), 32'h1);
        check("a_hold_set", 32'(cpu_hold), 32'h1);
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("a_hold_mid", 32'(cpu_hold), 32'h1);
        send_byte(8'h9A);
        check("a_nwr", 32'(wr_addr.size() - wb), 32'd3);
        check("a_wa0", 32'(wr_addr[wb]), 32'h0010);
        check("a_wd0", 32'(wr_data[wb]), 32'h11);
        check("a_wa1", 32'(wr_addr[wb+1]), 32'h0011);
        check("a_wd1", 32'(wr_data[wb+1]), 32'h22);
        check("a_wa2", 32'(wr_addr[wb+2]), 32'h0012);
        check("a_wd2", 32'(wr_data[wb+2]), 32'h33);
        check("a_done", 32'(done_cnt - db), 32'd1);
        check("a_hold", 32'(cpu_hold), 32'h0);
        check("a_err", 32'(load_err), 32'h0);
        check("a_busy_end", 32'(busy), 32'h0);

        // Same frame, bad checksum
        mark();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h9B);
        check("b_nwr", 32'(wr_addr.size() - wb), 32'd3);
        check("b_err", 32'(load_err), 32'h1);
        check("b_hold", 32'(cpu_hold), 32'h1);
        check("b_done", 32'(done_cnt - db), 32'd0);
        check("b_busy", 32'(busy), 32'h0);

        // Address wrap 0x3FFF -> 0x0000
        mark();
        send_byte(8'hA5);
        check("c_err_clr", 32'(load_err), 32'h0);
        send_byte(8'h3F); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'hFD);
        check("c_nwr", 32'(wr_addr.size() - wb), 32'd2);
        check("c_wa0", 32'(wr_addr[wb]), 32'h3FFF);
        check("c_wd0", 32'(wr_data[wb]), 32'h01);
        check("c_wa1", 32'(wr_addr[wb+1]), 32'h0000);
        check("c_wd1", 32'(wr_data[wb+1]), 32'h02);
        check("c_done", 32'(done_cnt - db), 32'd1);
        check("c_hold", 32'(cpu_hold), 32'h0);

        // Leading garbage, then an empty frame
        mark();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("d_garbage_busy", 32'(busy), 32'h0);
        check("d_garbage_hold", 32'(cpu_hold), 32'h0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("d_csum_busy", 32'(busy), 32'h1);
        send_byte(8'h00);
        check("d_nwr", 32'(wr_addr.size() - wb), 32'd0);
        check("d_done", 32'(done_cnt - db), 32'd1);
        check("d_busy", 32'(busy), 32'h0);
        check("d_hold", 32'(cpu_hold), 32'h0);

        // Timeout after LEN_L, then a good frame recovers
        mark();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h02);
        check("e_busy_pre", 32'(busy), 32'h1);
        check("e_err_pre", 32'(load_err), 32'h0);
        repeat (TIMEOUT + 10) @(negedge clk);
        check("e_err", 32'(load_err), 32'h1);
        check("e_busy", 32'(busy), 32'h0);
        check("e_hold", 32'(cpu_hold), 32'h1);
        check("e_nwr", 32'(wr_addr.size() - wb), 32'd0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'hAB);
        check("e2_nwr", 32'(wr_addr.size() - wb), 32'd1);
        check("e2_wa", 32'(wr_addr[wb]), 32'h0020);
        check("e2_wd", 32'(wr_data[wb]), 32'h55);
        check("e2_err", 32'(load_err), 32'h0);
        check("e2_hold", 32'(cpu_hold), 32'h0);
        check("e2_done", 32'(done_cnt - db), 32'd1);

        // Reset during DATA
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h30); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h10); send_byte(8'h20);
        check("f_busy_pre", 32'(busy), 32'h1);
        check("f_addr_pre", 32'(prg_addr), 32'h0031);
        reset_n = 1'b0;
        #1;
        check("f_addr", 32'(prg_addr), 32'h0);
        check("f_data", 32'(prg_data), 32'h0);
        check("f_wren", 32'(prg_wren), 32'h0);
        check("f_hold", 32'(cpu_hold), 32'h0);
        check("f_err", 32'(load_err), 32'h0);
        check("f_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mark();
        send_byte(8'h77);
        check("f_ign_busy", 32'(busy), 32'h0);
        check("f_ign_nwr", 32'(wr_addr.size() - wb), 32'd0);
        send_byte(8'hA5);
        check("f_sync_busy", 32'(busy), 32'h1);
        check("f_sync_hold", 32'(cpu_hold), 32'h1);

        check("wren_single", 32'(wren_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
